// File: rtl/uart_frame_receiver.sv
// Receives a HEADER-framed 4-byte payload plus XOR checksum from a UART byte stream.
// Presents the assembled 32-bit word with a one-cycle valid pulse, or flags errors.
module uart_frame_receiver #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_done_tick,
    input  logic [7:0]  r_data,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, B1, B2, B3, B4, CHK} state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    shift_reg;
    logic [7:0]     xor_sum;
    logic [CW-1:0]  timeout_cnt;
    logic           start;
    logic           shift_en;
    logic           chk_good;
    logic           chk_bad;
    logic           timed_out;
    logic           timeout_hit;

    assign busy        = (state != IDLE);
    assign timeout_hit = (timeout_cnt == TMAX);

    // A tick always takes priority over a coincident timeout.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift_en   = 1'b0;
        chk_good   = 1'b0;
        chk_bad    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done_tick && r_data == HEADER) begin
                    state_next = B1;
                    start      = 1'b1;
                end
            end
            B1, B2, B3, B4: begin
                if (rx_done_tick) begin
                    shift_en = 1'b1;
                    case (state)
                        B1:      state_next = B2;
                        B2:      state_next = B3;
                        B3:      state_next = B4;
                        default: state_next = CHK;
                    endcase
                end else if (timeout_hit) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            CHK: begin
                if (rx_done_tick) begin
                    if (r_data == xor_sum) chk_good = 1'b1;
                    else                   chk_bad  = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            xor_sum     <= '0;
            timeout_cnt <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            data_valid  <= chk_good;
            frame_error <= chk_bad | timed_out;
            if (start) begin
                xor_sum <= '0;
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[23:0], r_data};
                xor_sum   <= xor_sum ^ r_data;
            end
            if (chk_good) begin
                data_out <= shift_reg;
            end
            if (state == IDLE || state_next == IDLE || rx_done_tick) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver: table-driven byte vectors plus
// hand-written timeout, tick-vs-timeout tie and mid-frame reset sequences.
module tb_uart_frame_receiver;

    localparam int TO = 50;

    logic        clk;
    logic        reset_n;
    logic        rx_done_tick;
    logic [7:0]  r_data;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_frame_receiver #(.HEADER(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_done_tick (rx_done_tick),
        .r_data       (r_data),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic        e;
        logic        bsy;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] b, logic v, logic e, logic bsy, logic [31:0] d);
        vec_t r;
        r.b = b; r.v = v; r.e = e; r.bsy = bsy; r.d = d;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drives one tick on a falling edge; returns #1 after the sampling rising edge.
    task automatic apply_stimulus(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        r_data       = b;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        r_data       = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4, input logic [7:0] cs, output int valids, output int errs);
        logic [7:0] bytes [6];
        bytes[0] = 8'hA5; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3; bytes[4] = b4; bytes[5] = cs;
        valids = 0;
        errs   = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(bytes[i]);
            if (data_valid)  valids++;
            if (frame_error) errs++;
        end
    endtask

    initial begin
        int hit_at;
        int nv;
        int ne;

        reset_n      = 1'b0;
        rx_done_tick = 1'b0;
        r_data       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_data_out", data_out, 32'h0);
        check_output("reset_valid", {31'b0, data_valid}, 32'h0);
        check_output("reset_error", {31'b0, frame_error}, 32'h0);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // good frame, bad checksum, leading garbage, header bytes as payload
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'h0));
        vecs.push_back(mk(8'h12, 0, 0, 1, 32'h0));
        vecs.push_back(mk(8'h34, 0, 0, 1, 32'h0));
        vecs.push_back(mk(8'h56, 0, 0, 1, 32'h0));
        vecs.push_back(mk(8'h78, 0, 0, 1, 32'h0));
        vecs.push_back(mk(8'h08, 1, 0, 0, 32'h12345678));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'h12, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'h34, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'h56, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'h78, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'h09, 0, 1, 0, 32'h12345678));
        vecs.push_back(mk(8'h00, 0, 0, 0, 32'h12345678));
        vecs.push_back(mk(8'hFF, 0, 0, 0, 32'h12345678));
        vecs.push_back(mk(8'h3C, 0, 0, 0, 32'h12345678));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'hDE, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'hAD, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'hBE, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'hEF, 0, 0, 1, 32'h12345678));
        vecs.push_back(mk(8'h22, 1, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(8'hA5, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(8'h00, 1, 0, 0, 32'hA5A5A5A5));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].b);
            check_output($sformatf("vec%0d_valid", i), {31'b0, data_valid}, {31'b0, vecs[i].v});
            check_output($sformatf("vec%0d_error", i), {31'b0, frame_error}, {31'b0, vecs[i].e});
            check_output($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].bsy});
            check_output($sformatf("vec%0d_data", i), data_out, vecs[i].d);
        end
        @(posedge clk);
        #1;
        check_output("valid_one_cycle", {31'b0, data_valid}, 32'h0);

        // timeout: error must land exactly TO edges after the last tick
        apply_stimulus(8'hA5);
        apply_stimulus(8'h12);
        apply_stimulus(8'h34);
        hit_at = -1;
        for (int k = 1; k <= TO + 10; k++) begin
            @(posedge clk);
            #1;
            if (frame_error) begin
                hit_at = k;
                break;
            end
        end
        check_output("timeout_cycle", hit_at, TO);
        check_output("timeout_busy", {31'b0, busy}, 32'h0);
        check_output("timeout_valid", {31'b0, data_valid}, 32'h0);
        @(posedge clk);
        #1;
        check_output("timeout_err_one_cycle", {31'b0, frame_error}, 32'h0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, nv, ne);
        check_output("after_timeout_valids", nv, 1);
        check_output("after_timeout_errs", ne, 0);
        check_output("after_timeout_data", data_out, 32'h01020304);

        // tick lands on the exact timeout cycle and must be accepted
        apply_stimulus(8'hA5);
        apply_stimulus(8'h11);
        ne = 0;
        for (int k = 1; k < TO; k++) begin
            @(posedge clk);
            #1;
            if (frame_error) ne++;
        end
        apply_stimulus(8'h22);
        check_output("tie_no_early_error", ne, 0);
        check_output("tie_error", {31'b0, frame_error}, 32'h0);
        check_output("tie_busy", {31'b0, busy}, 32'h1);
        apply_stimulus(8'h33);
        apply_stimulus(8'h44);
        apply_stimulus(8'h44);
        check_output("tie_valid", {31'b0, data_valid}, 32'h1);
        check_output("tie_data", data_out, 32'h11223344);

        // asynchronous reset mid-frame discards the partial frame
        apply_stimulus(8'hA5);
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_output("rst_data_out", data_out, 32'h0);
        check_output("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, nv, ne);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (data_valid) nv++;
            if (frame_error) ne++;
        end
        check_output("rst_frame_valids", nv, 1);
        check_output("rst_frame_errs", ne, 0);
        check_output("rst_frame_data", data_out, 32'h01020304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Receive-side counterpart of the 4-byte temperature frame sender.
- Consumes bytes from the UART receiver (rx_done_tick/r_data).
- Detects a header byte, assembles four payload bytes MSB-first into a 32-bit word, and checks an XOR checksum byte.
- On a good frame, presents the word with a one-cycle valid pulse. Used on the host-side/loopback FPGA to recover MAX31855 readings or 32-bit commands.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 100000, max clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_done_tick  input  1  one-cycle pulse: r_data holds a newly received byte.
- r_data  input  8  received byte; valid only when rx_done_tick=1.
- data_out  output  32  last good frame payload; byte1 in [31:24], byte4 in [7:0].
- data_valid  output  1  one-cycle pulse when data_out is updated by a good frame.
- frame_error  output  1  one-cycle pulse on checksum mismatch or inter-byte timeout.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; data_out=0, data_valid=0, frame_error=0, busy=0.
  - Shift register, running XOR and timeout counter cleared.
  - Applies immediately mid-frame; the partial frame is discarded.
- States: IDLE, B1, B2, B3, B4, CHK. Transitions occur only on rx_done_tick, except timeout.
- IDLE:
  - On tick with r_data==HEADER: go to B1, clear XOR, clear timeout counter.
  - Any other byte is ignored; state stays IDLE and no error is flagged.
- B1..B4:
  - On tick: shift the byte into the assembly register (B1 byte lands in [31:24]), XOR it into the running checksum, advance to the next state (B4 -> CHK).
  - A HEADER value here is treated as payload, not as a resync.
- CHK:
  - On tick, compare r_data with the running XOR.
  - Match: data_out <= assembled word; data_valid=1 for exactly one cycle.
  - Mismatch: frame_error=1 for one cycle; data_out unchanged.
  - Either way, return to IDLE.
- Latency: data_valid/frame_error are registered and assert on the clk edge that samples the checksum tick. They are visible during the cycle after the tick.
- Timeout:
  - Counter runs in B1..CHK and clears on every rx_done_tick.
  - When it reaches TIMEOUT_CYCLES-1 with no tick: frame_error pulses for one cycle and the state goes to IDLE.
  - Counter is held at 0 in IDLE.
  - Width: clog2(TIMEOUT_CYCLES)+1 bits, no wrap.
- Simultaneous tick and timeout on the same cycle: the tick wins; the byte is accepted and no error is raised.
- data_valid and frame_error are never high in the same cycle. Both are 0 on every cycle not listed above.
- busy is combinational from state (state != IDLE).
- Back-to-back frames: a HEADER tick arriving the cycle after CHK completes is accepted normally.

Test Plan:
- Good frame: bytes A5 12 34 56 78 08 -> one data_valid pulse, data_out=32'h12345678, frame_error never high, busy low afterwards.
- Bad checksum: A5 12 34 56 78 09 -> frame_error pulse, no data_valid, data_out keeps its prior value (32'h12345678 after the previous test).
- Leading garbage: 00 FF 3C, then A5 DE AD BE EF 22 -> garbage ignored with no error; data_out=32'hDEADBEEF with data_valid.
- Timeout: A5 12 34, then idle for TIMEOUT_CYCLES (parameter overridden to 50) -> frame_error pulse at cycle 50 after the last tick, busy drops. The following full frame A5 01 02 03 04 04 then yields 32'h01020304.
- Header as payload: A5 A5 A5 A5 A5 00 -> data_out=32'hA5A5A5A5, data_valid pulse. Also check the tick-vs-timeout tie: a tick exactly on the timeout cycle is accepted with no error.
- Reset mid-frame: A5 11 22, pulse reset_n low for 1 cycle, then A5 01 02 03 04 04 -> data_out=0 immediately after reset, then 32'h01020304 with exactly one data_valid.
